// File: rtl/tone_sequencer.sv
// Multi-channel buzzer sequencer: per-channel note tables, fixed-priority
// arbitration with preemption, and a square-wave tone generator.
module tone_sequencer #(
    parameter int CLK_HZ    = 100000000,
    parameter int NUM_CH    = 4,
    parameter int MAX_STEPS = 8,
    parameter int DIV_W     = 18,
    parameter int DUR_W     = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            trig,
    input  logic [NUM_CH-1:0]            repeat_mode,
    input  logic                         mute,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_CH)-1:0]    wr_ch,
    input  logic [$clog2(MAX_STEPS)-1:0] wr_step,
    input  logic [DIV_W-1:0]             wr_div,
    input  logic [DUR_W-1:0]             wr_dur,
    input  logic                         wr_last,
    output logic                         buzzer,
    output logic                         busy,
    output logic [$clog2(NUM_CH)-1:0]    active_ch,
    output logic [NUM_CH-1:0]            done
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ST_W  = $clog2(MAX_STEPS);
    localparam int TC    = CLK_HZ / 1000;
    localparam int PRE_W = (TC > 1) ? $clog2(TC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    logic [DIV_W-1:0]  tbl_div_r  [NUM_CH][MAX_STEPS];
    logic [DUR_W-1:0]  tbl_dur_r  [NUM_CH][MAX_STEPS];
    logic              tbl_last_r [NUM_CH][MAX_STEPS];

    state_t            state_r;
    logic [CH_W-1:0]   ch_r;
    logic [ST_W-1:0]   step_r;
    logic [NUM_CH-1:0] pending_r;
    logic [DIV_W-1:0]  div_r;
    logic [DUR_W-1:0]  dur_r;
    logic              last_r;
    logic [PRE_W-1:0]  pre_cnt_r;
    logic [DUR_W-1:0]  ms_cnt_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic              tone_r;
    logic              buzzer_r;
    logic              busy_r;
    logic [CH_W-1:0]   active_ch_r;
    logic [NUM_CH-1:0] done_r;

    logic [NUM_CH-1:0] play_mask_s;
    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] take_mask_s;
    logic [NUM_CH-1:0] pend_nxt_s;
    logic              sel_valid_s;
    logic [CH_W-1:0]   sel_ch_s;
    logic              preempt_s;
    logic              take_s;
    logic              tick_s;
    logic              step_end_s;
    logic              tone_wrap_s;
    logic [DIV_W-1:0]  rd_div_s;
    logic [DUR_W-1:0]  rd_dur_s;
    logic              rd_last_s;

    assign buzzer    = buzzer_r;
    assign busy      = busy_r;
    assign active_ch = active_ch_r;
    assign done      = done_r;

    // Request capture, lowest-index arbitration and step/tone timing strobes
    always_comb begin
        play_mask_s = '0;
        if (state_r != S_IDLE) begin
            play_mask_s[ch_r] = 1'b1;
        end else begin
            play_mask_s = '0;
        end
        // A retrigger of the playing channel is dropped, never queued
        req_s       = pending_r | (trig & ~play_mask_s);
        sel_valid_s = |req_s;
        sel_ch_s    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sel_ch_s = req_s[i] ? CH_W'(i) : sel_ch_s;
        end
        preempt_s   = (state_r != S_IDLE) && sel_valid_s && (sel_ch_s < ch_r);
        take_s      = sel_valid_s && ((state_r == S_IDLE) || preempt_s);
        take_mask_s = take_s ? ({{(NUM_CH-1){1'b0}}, 1'b1} << sel_ch_s) : '0;
        pend_nxt_s  = req_s & ~take_mask_s;
        tick_s      = (pre_cnt_r == PRE_W'(TC - 1));
        step_end_s  = (state_r == S_PLAY) && tick_s && (ms_cnt_r == dur_r - DUR_W'(1));
        tone_wrap_s = (div_r != '0) && (div_cnt_r == div_r - DIV_W'(1));
        rd_div_s    = tbl_div_r[ch_r][step_r];
        rd_dur_s    = tbl_dur_r[ch_r][step_r];
        rd_last_s   = tbl_last_r[ch_r][step_r];
    end

    // Note table storage; every entry resets to a 1 ms rest ending the sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < MAX_STEPS; s++) begin
                    tbl_div_r[c][s]  <= '0;
                    tbl_dur_r[c][s]  <= DUR_W'(1);
                    tbl_last_r[c][s] <= 1'b1;
                end
            end
        end else if (wr_en && (int'(wr_ch) < NUM_CH) && (int'(wr_step) < MAX_STEPS)) begin
            tbl_div_r[wr_ch][wr_step]  <= wr_div;
            tbl_dur_r[wr_ch][wr_step]  <= wr_dur;
            tbl_last_r[wr_ch][wr_step] <= wr_last;
        end
    end

    // Sequencer FSM with step timing, tone generation and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            ch_r        <= '0;
            step_r      <= '0;
            pending_r   <= '0;
            div_r       <= '0;
            dur_r       <= DUR_W'(1);
            last_r      <= 1'b1;
            pre_cnt_r   <= '0;
            ms_cnt_r    <= '0;
            div_cnt_r   <= '0;
            tone_r      <= 1'b0;
            buzzer_r    <= 1'b0;
            busy_r      <= 1'b0;
            active_ch_r <= '0;
            done_r      <= '0;
        end else begin
            pending_r <= pend_nxt_s;
            done_r    <= '0;
            case (state_r)
                S_IDLE: begin
                    buzzer_r <= 1'b0;
                    tone_r   <= 1'b0;
                    if (sel_valid_s) begin
                        state_r     <= S_LOAD;
                        ch_r        <= sel_ch_s;
                        step_r      <= '0;
                        busy_r      <= 1'b1;
                        active_ch_r <= sel_ch_s;
                    end else begin
                        busy_r      <= 1'b0;
                        active_ch_r <= '0;
                    end
                end
                S_LOAD: begin
                    buzzer_r <= 1'b0;
                    tone_r   <= 1'b0;
                    if (preempt_s) begin
                        ch_r        <= sel_ch_s;
                        step_r      <= '0;
                        active_ch_r <= sel_ch_s;
                    end else begin
                        div_r     <= rd_div_s;
                        dur_r     <= (rd_dur_s == '0) ? DUR_W'(1) : rd_dur_s;
                        last_r    <= rd_last_s;
                        pre_cnt_r <= '0;
                        ms_cnt_r  <= '0;
                        div_cnt_r <= '0;
                        state_r   <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (step_end_s && last_r) begin
                        done_r[ch_r] <= 1'b1;
                    end
                    if (preempt_s) begin
                        state_r     <= S_LOAD;
                        ch_r        <= sel_ch_s;
                        step_r      <= '0;
                        active_ch_r <= sel_ch_s;
                        tone_r      <= 1'b0;
                        buzzer_r    <= 1'b0;
                    end else if (step_end_s) begin
                        tone_r   <= 1'b0;
                        buzzer_r <= 1'b0;
                        if (!last_r) begin
                            // Index wraps naturally at MAX_STEPS
                            step_r  <= step_r + ST_W'(1);
                            state_r <= S_LOAD;
                        end else if (repeat_mode[ch_r] && trig[ch_r]) begin
                            step_r  <= '0;
                            state_r <= S_LOAD;
                        end else begin
                            state_r     <= S_IDLE;
                            busy_r      <= 1'b0;
                            active_ch_r <= '0;
                        end
                    end else begin
                        pre_cnt_r <= tick_s ? '0 : pre_cnt_r + PRE_W'(1);
                        ms_cnt_r  <= tick_s ? ms_cnt_r + DUR_W'(1) : ms_cnt_r;
                        div_cnt_r <= (tone_wrap_s || (div_r == '0)) ? '0 : div_cnt_r + DIV_W'(1);
                        tone_r    <= tone_r ^ tone_wrap_s;
                        buzzer_r  <= (tone_r ^ tone_wrap_s) & ~mute;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    active_ch_r <= '0;
                    buzzer_r    <= 1'b0;
                    tone_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: cycle model of the playback rules
// plus hand-computed expectations for each directed scenario.
module tb_tone_sequencer;
    localparam int CLK_HZ    = 10000;
    localparam int NUM_CH    = 4;
    localparam int MAX_STEPS = 8;
    localparam int DIV_W     = 18;
    localparam int DUR_W     = 12;
    localparam int TC        = CLK_HZ / 1000;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        trig;
    logic [3:0]        repeat_mode;
    logic              mute;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic [2:0]        wr_step;
    logic [DIV_W-1:0]  wr_div;
    logic [DUR_W-1:0]  wr_dur;
    logic              wr_last;
    logic              buzzer;
    logic              busy;
    logic [1:0]        active_ch;
    logic [3:0]        done;

    tone_sequencer #(
        .CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .MAX_STEPS(MAX_STEPS), .DIV_W(DIV_W), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig), .repeat_mode(repeat_mode), .mute(mute),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_step(wr_step), .wr_div(wr_div), .wr_dur(wr_dur),
        .wr_last(wr_last), .buzzer(buzzer), .busy(busy), .active_ch(active_ch), .done(done)
    );

    always #5 clk = ~clk;

    int mdl_checks = 0;
    int mdl_fail   = 0;
    int lit_checks = 0;
    int lit_fail   = 0;

    // Behavioural model state: what is playing and how far into the note it is
    int         m_div_t  [NUM_CH][MAX_STEPS];
    int         m_dur_t  [NUM_CH][MAX_STEPS];
    bit         m_last_t [NUM_CH][MAX_STEPS];
    logic [3:0] m_pend;
    bit         m_busy, m_load, m_last, m_ready = 1'b0;
    int         m_ch, m_step, m_el, m_div, m_dur;
    bit         e_buz, e_busy;
    int         e_ach;
    logic [3:0] e_done;

    always @(posedge clk) begin : model
        logic [3:0] req;
        logic [3:0] mask;
        int sel;
        bit fin, took;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < MAX_STEPS; s++) begin
                    m_div_t[c][s] = 0; m_dur_t[c][s] = 1; m_last_t[c][s] = 1'b1;
                end
            end
            m_pend = 4'b0000; m_busy = 1'b0; m_load = 1'b0; m_ch = 0; m_step = 0;
            m_el = 0; m_div = 0; m_dur = 1; m_last = 1'b1; e_done = 4'b0000; m_ready = 1'b1;
        end else begin
            mask = m_busy ? (4'b0001 << m_ch) : 4'b0000;
            req  = m_pend | (trig & ~mask);
            sel  = -1;
            for (int i = NUM_CH - 1; i >= 0; i--) if (req[i]) sel = i;
            fin    = m_busy && !m_load && (m_el + 1 == m_dur * TC);
            took   = 1'b0;
            e_done = 4'b0000;
            if (fin && m_last) e_done[m_ch] = 1'b1;
            if (sel >= 0 && (!m_busy || sel < m_ch)) begin
                m_busy = 1'b1; m_ch = sel; m_step = 0; m_load = 1'b1; took = 1'b1;
            end else if (m_busy && m_load) begin
                m_div  = m_div_t[m_ch][m_step];
                m_dur  = (m_dur_t[m_ch][m_step] == 0) ? 1 : m_dur_t[m_ch][m_step];
                m_last = m_last_t[m_ch][m_step];
                m_load = 1'b0; m_el = 0;
            end else if (fin) begin
                if (!m_last) begin
                    m_step = (m_step + 1) % MAX_STEPS; m_load = 1'b1;
                end else if (repeat_mode[m_ch] && trig[m_ch]) begin
                    m_step = 0; m_load = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (m_busy) begin
                m_el++;
            end
            m_pend = took ? (req & ~(4'b0001 << sel)) : req;
            if (wr_en && int'(wr_ch) < NUM_CH) begin
                m_div_t[wr_ch][wr_step]  = int'(wr_div);
                m_dur_t[wr_ch][wr_step]  = int'(wr_dur);
                m_last_t[wr_ch][wr_step] = wr_last;
            end
        end
        e_busy = m_busy;
        e_ach  = m_busy ? m_ch : 0;
        e_buz  = m_busy && !m_load && (m_div != 0) && (((m_el / m_div) % 2) == 1) && !mute;
    end

    task automatic mchk(input string name, input int act, input int exp);
        mdl_checks++;
        if (act != exp) begin
            mdl_fail++;
            $display("FAIL model %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (m_ready) begin
            mchk("buzzer", int'(buzzer), int'(e_buz));
            mchk("busy", int'(busy), int'(e_busy));
            mchk("active_ch", int'(active_ch), e_ach);
            mchk("done", int'(done), int'(e_done));
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        lit_checks++;
        if (act != exp) begin
            lit_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int   cnt_busy, cnt_buz, first_busy;
    int   cnt_done  [NUM_CH];
    int   first_done[NUM_CH];
    int   cnt_ach   [NUM_CH];
    int   ach_k2;
    logic buz_last;

    task automatic wr_entry(input int ch, input int step, input int dv, input int du, input bit lst);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_step = 3'(step);
        wr_div = DIV_W'(dv); wr_dur = DUR_W'(du); wr_last = lst;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Apply trig pattern t for `hold` cycles, observe n cycles, optional mute window
    task automatic run_window(input logic [3:0] t, input int hold, input int n,
                              input int m_on, input int m_off);
        cnt_busy = 0; cnt_buz = 0; first_busy = 0; ach_k2 = -1; buz_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_done[i] = 0; first_done[i] = 0; cnt_ach[i] = 0;
        end
        trig = t;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (busy) begin
                cnt_busy++;
                cnt_ach[active_ch]++;
                if (first_busy == 0) first_busy = k;
            end
            if (buzzer) cnt_buz++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (done[i]) begin
                    cnt_done[i]++;
                    if (first_done[i] == 0) first_done[i] = k;
                end
            end
            if (k == 2) ach_k2 = int'(active_ch);
            buz_last = buzzer;
            if (k == hold) trig = 4'b0000;
            if (k == m_on) mute = 1'b1;
            if (k == m_off) mute = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; trig = 4'b0000; repeat_mode = 4'b0000; mute = 1'b0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_step = 3'd0; wr_div = '0; wr_dur = '0; wr_last = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset buzzer", int'(buzzer), 0);
        lit("reset busy", int'(busy), 0);
        lit("reset active_ch", int'(active_ch), 0);
        lit("reset done", int'(done), 0);
        reset = 1'b0;

        wr_entry(1, 0, 2, 3, 1'b0);
        wr_entry(1, 1, 0, 1, 1'b1);
        wr_entry(0, 0, 1, 2, 1'b1);
        wr_entry(3, 0, 3, 5, 1'b1);

        // Basic two-step melody on channel 1
        run_window(4'b0010, 1, 60, 0, 0);
        lit("t1 busy start", first_busy, 1);
        lit("t1 busy cycles", cnt_busy, 42);
        lit("t1 buzzer high", cnt_buz, 14);
        lit("t1 done count", cnt_done[1], 1);
        lit("t1 done cycle", first_done[1], 43);

        // Simultaneous trig on 2 and 0
        run_window(4'b0101, 1, 60, 0, 0);
        lit("t2 ch0 cycles", cnt_ach[0], 21);
        lit("t2 ch2 cycles", cnt_ach[2], 11);
        lit("t2 done0 cycle", first_done[0], 22);
        lit("t2 done2 cycle", first_done[2], 34);
        lit("t2 busy cycles", cnt_busy, 32);

        // Channel 3 preempted by channel 1
        run_window(4'b1000, 1, 20, 0, 0);
        lit("t3 ch3 playing", cnt_ach[3], 20);
        run_window(4'b0010, 1, 60, 0, 0);
        lit("t3 active after preempt", ach_k2, 1);
        lit("t3 no done3", cnt_done[3], 0);
        lit("t3 done1 cycle", first_done[1], 43);
        lit("t3 no resume", cnt_busy, 42);

        // Repeat mode with trig held for three sequence lengths
        repeat_mode = 4'b0001;
        run_window(4'b0001, 63, 90, 0, 0);
        lit("t4 done0 count", cnt_done[0], 3);
        lit("t4 busy cycles", cnt_busy, 63);
        lit("t4 last done", first_done[0], 22);
        repeat_mode = 4'b0000;

        // Mute during a note
        run_window(4'b0010, 1, 60, 10, 20);
        lit("t5 buzzer high", cnt_buz, 9);
        lit("t5 busy cycles", cnt_busy, 42);
        lit("t5 done cycle", first_done[1], 43);

        // Step wrap without a last flag, then preemption by channel 0
        for (int s = 0; s < MAX_STEPS; s++) wr_entry(3, s, 1, (s == 0) ? 0 : 1, 1'b0);
        run_window(4'b1000, 1, 120, 0, 0);
        lit("t6 wrap busy", cnt_ach[3], 120);
        lit("t6 wrap no done", cnt_done[3], 0);
        run_window(4'b0001, 1, 40, 0, 0);
        lit("t6 preempt ch0", cnt_ach[0], 21);
        lit("t6 ch3 gone", cnt_ach[3], 0);
        lit("t6 done0 cycle", first_done[0], 22);

        // Reset mid-note, then default table entry
        run_window(4'b0010, 1, 9, 0, 0);
        lit("t7 buzzer before reset", int'(buz_last), 1);
        reset = 1'b1;
        @(negedge clk);
        lit("t7 reset buzzer", int'(buzzer), 0);
        lit("t7 reset busy", int'(busy), 0);
        reset = 1'b0;
        run_window(4'b0010, 1, 20, 0, 0);
        lit("t7 default busy", cnt_busy, 11);
        lit("t7 default silent", cnt_buz, 0);
        lit("t7 default done", first_done[1], 12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 mdl_checks + lit_checks, mdl_fail + lit_fail);
        $finish;
    end
endmodule
